// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA raster path (640x480@60 defaults).
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int CNT_W       = 11;
  localparam int COLOR_DEPTH = 8;

  typedef enum logic [1:0] {PH_VIS, PH_FRONT, PH_SYNC, PH_BACK} phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus VIS/FRONT/SYNC/BACK phase tracker.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output phase_e           phase,
  output logic             wrap,
  output logic             sync_n,
  output logic             active
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  // Last count of each phase; the phase advances as the counter leaves it.
  localparam logic [CNT_W-1:0] LAST_VIS   = CNT_W'(VISIBLE - 1);
  localparam logic [CNT_W-1:0] LAST_FRONT = CNT_W'(VISIBLE + FRONT - 1);
  localparam logic [CNT_W-1:0] LAST_SYNC  = CNT_W'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  phase_e           phase_q, phase_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      phase_q <= PH_VIS;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    wrap    = 1'b0;
    if (tick) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
      case (phase_q)
        PH_VIS:   if (count_q == LAST_VIS)   phase_d = PH_FRONT;
        PH_FRONT: if (count_q == LAST_FRONT) phase_d = PH_SYNC;
        PH_SYNC:  if (count_q == LAST_SYNC)  phase_d = PH_BACK;
        PH_BACK:  if (count_q == LAST)       phase_d = PH_VIS;
        default:  phase_d = PH_VIS;
      endcase
    end
  end

  assign count  = count_q;
  assign phase  = phase_q;
  assign active = (phase_q == PH_VIS);
  assign sync_n = (phase_q != PH_SYNC);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: registered, mutually aligned position, active-video,
// sync and frame_start outputs, advanced one pixel per pix_en strobe.
module vga_sync_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_en,
  output logic [CNT_W-1:0] row,
  output logic [CNT_W-1:0] col,
  output logic             output_valid,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start
);

  logic [CNT_W-1:0] h_count, v_count;
  phase_e           h_phase, v_phase;
  logic             h_wrap, v_wrap, h_sync_n, v_sync_n, h_active, v_active;
  logic             unused_axis;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(clk), .rst(rst), .tick(pix_en),
    .count(h_count), .phase(h_phase), .wrap(h_wrap),
    .sync_n(h_sync_n), .active(h_active)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(clk), .rst(rst), .tick(pix_en & h_wrap),
    .count(v_count), .phase(v_phase), .wrap(v_wrap),
    .sync_n(v_sync_n), .active(v_active)
  );

  // Phases are already folded into active/sync_n; the frame wrap is implied by (0,0).
  assign unused_axis = ^{h_phase, v_phase, v_wrap};

  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic             valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;

  always_comb begin
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    fs_d    = 1'b0;
    if (pix_en) begin
      row_d   = v_count;
      col_d   = h_count;
      valid_d = h_active & v_active;
      hsync_d = h_sync_n;
      vsync_d = v_sync_n;
      fs_d    = (h_count == '0) && (v_count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end

  assign row          = row_q;
  assign col          = col_q;
  assign output_valid = valid_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign frame_start  = fs_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the VGA output path. Produces the pixel position (`row`, `col`), active-video qualifier (`output_valid`) and sync pulses for the default 640x480@60 mode. Sits directly upstream of the colour generator, which turns `row`/`col`/`output_valid` into 8-bit RRRGGGBB pixels, and beside the DAC/pin drivers, which take `hsync`/`vsync`. Advances one pixel per `pix_en` strobe, so it runs from a system clock faster than the pixel rate.

## Interface
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `clk`  in  1  system clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset
- `pix_en`  in  1  pixel-rate strobe; one pulse = one pixel period
- `row`  out  11  current line, 0..V_TOTAL-1
- `col`  out  11  current pixel, 0..H_TOTAL-1
- `output_valid`  out  1  high when col < H_VISIBLE and row < V_VISIBLE
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `frame_start`  out  1  one-clk pulse when (0,0) is presented

## Operation
- H_TOTAL = sum of the four H params (800); V_TOTAL = sum of the four V params (525). Both must be ≤ 2047, and every param must be ≥ 1.
- Internal counters `h_cnt` and `v_cnt` hold the next position to present.
- On each `pix_en`:
  - outputs load the decode of (`h_cnt`, `v_cnt`);
  - `h_cnt` increments, wrapping at H_TOTAL-1 → 0;
  - on an h wrap, `v_cnt` increments, wrapping at V_TOTAL-1 → 0.
- Phase FSM per axis: VIS → FRONT → SYNC → BACK → VIS. Each transition happens when the axis counter reaches its phase boundary. The vertical FSM only steps on an h wrap.
- Decode rules:
  - `hsync` = 0 iff count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - `vsync` = 0 iff v count in [490, 491].
  - `col` and `row` report raw counts during blanking as well as active video.
- `pix_en` low: all outputs and counters hold, except `frame_start`, which clears to 0 on the next clk.
- `frame_start` lasts exactly one clk, even if `pix_en` is held high continuously.

## Timing
- Reset values:
  - outputs: `row`=0, `col`=0, `output_valid`=0, `hsync`=1, `vsync`=1, `frame_start`=0;
  - counters: `h_cnt`=0, `v_cnt`=0;
  - both FSMs in VIS.
- Latency: outputs update on the clk edge where `pix_en`=1 is sampled, presenting the pre-increment count. The first `pix_en` after reset presents (0,0) with `output_valid`=1 and `frame_start`=1.
- All outputs are registered and mutually aligned; no combinational path from inputs to outputs.
- `rst` wins over `pix_en` in the same cycle.
- Reset mid-frame: the next `pix_en` restarts at (0,0), with no partial sync pulse carried over.
- Wraps:
  - col 799 → 0 with row+1 in the same update;
  - (799, 524) → (0, 0) with `frame_start`=1.

## Structure
- Shared package `vga_pkg`:
  - default timing constants for the 640x480 mode;
  - derived H_TOTAL and V_TOTAL;
  - phase enum {VIS, FRONT, SYNC, BACK};
  - `COLOR_DEPTH` = 8, for the downstream colour generator.
- Sub-module `vga_axis_counter`, instantiated once per axis:
  - params: VISIBLE, FRONT, SYNC, BACK;
  - inputs: clk, rst, tick;
  - outputs: count[10:0], phase, wrap, sync_n, active.
  - Horizontal instance: `tick` = `pix_en`.
  - Vertical instance: `tick` = `pix_en` & horizontal `wrap`.
- Top level holds the aligned output registers and the `frame_start` logic.

## Test plan
- Reset, with `pix_en`=0 for 10 clks → all outputs at their reset values and unchanged.
- Reset release, then `pix_en` every 4th clk → first update shows row=0, col=0, `output_valid`=1, `frame_start`=1. `frame_start` is 0 on the next clk.
- Run one line:
  - `hsync` falls when col=656 and rises when col=752;
  - `output_valid` falls at col=640;
  - col=799 is followed by col=0, row=1.
- Run a full frame:
  - `vsync` is 0 only for rows 490–491;
  - `output_valid` is 0 for all rows ≥ 480;
  - (799, 524) → (0, 0) with a single `frame_start` pulse;
  - exactly 420000 `pix_en` strobes occur between `frame_start` pulses.
- Hold `pix_en`=0 mid-line at col=300 for 50 clks → outputs frozen, then resume at col=301.
- Assert `rst` at row=200, col=400 in the same cycle as `pix_en` → reset values result; the next `pix_en` presents (0,0) with `frame_start`=1.
